// File: rtl/result_stream_drain.sv
// result_stream_drain
//   Downstream stage of the systolic matrix multiplier. On the one-cycle
//   `done` pulse the flat result vector is copied into a local snapshot and
//   the multiplier is free again at once. The M*P elements are then streamed
//   out row-major, one per valid/ready handshake, with no bubbles when the
//   consumer is always ready.
//
// Parameters
//   DATA_WIDTH  element width (matches a result_c slice)
//   M, P        result rows / columns
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   done          one-cycle pulse; result_c is valid in that cycle
//   result_c      flat result, element k=i*P+j at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_data      current element (registered)
//   out_valid     out_data valid
//   out_ready     consumer accepts when out_valid && out_ready
//   out_row       row index of out_data
//   out_col       column index of out_data
//   busy          high while a snapshot is being streamed
//   frame_done    one-cycle pulse after the final element is accepted
//   overrun       sticky; a done pulse arrived while streaming and was dropped
//   clr_overrun   synchronous clear of overrun (a same-cycle drop wins)
//   frame_count   frames fully streamed, wraps 255 -> 0
//   out_last      only with STREAM_LAST_EN defined: high with the final element
//
// Build option
//   STREAM_LAST_EN  adds the out_last port; otherwise frame_done is the only
//                   end-of-frame indication.

module result_stream_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int M          = 8,
  parameter int P          = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    done,
  input  logic [M*P*DATA_WIDTH-1:0]               result_c,
  output logic [DATA_WIDTH-1:0]                   out_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0]    out_row,
  output logic [((P > 1) ? $clog2(P) : 1)-1:0]    out_col,
  output logic                                    busy,
  output logic                                    frame_done,
  output logic                                    overrun,
  input  logic                                    clr_overrun,
  output logic [7:0]                              frame_count
`ifdef STREAM_LAST_EN
  ,
  output logic                                    out_last
`endif
);

  localparam int unsigned N     = M * P;
  localparam int          IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int          ROW_W = (M > 1) ? $clog2(M) : 1;
  localparam int          COL_W = (P > 1) ? $clog2(P) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(P - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;

  logic [DATA_WIDTH-1:0]   snapshot [N];
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_inc;

  logic                    capture;
  logic                    handshake;
  logic                    hs_last;
  logic                    drop;

  // out_valid and busy are both just "in STREAM"; state is a register, so
  // these outputs are registered as well.
  assign out_valid = (state == STREAM);
  assign busy      = (state == STREAM);

  always_comb begin
    capture   = 1'b0;
    handshake = 1'b0;
    hs_last   = 1'b0;
    drop      = 1'b0;
    idx_inc   = idx + IDX_W'(1);
    state_next = state;
    case (state)
      IDLE: begin
        if (done) begin
          capture    = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        // A done here (even on the final handshake) cannot be honoured:
        // the snapshot is still in use, so the result is dropped.
        drop      = done;
        handshake = out_ready;
        hs_last   = out_ready && (idx == LAST_IDX);
        if (hs_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < N; k++) begin
        snapshot[k] <= '0;
      end
      idx         <= '0;
      out_row     <= '0;
      out_col     <= '0;
      out_data    <= '0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
`ifdef STREAM_LAST_EN
      out_last    <= 1'b0;
`endif
    end else begin
      frame_done <= hs_last;

      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end

      if (capture) begin
        for (int unsigned k = 0; k < N; k++) begin
          snapshot[k] <= result_c[k*DATA_WIDTH +: DATA_WIDTH];
        end
        idx      <= '0;
        out_row  <= '0;
        out_col  <= '0;
        // Element 0 comes straight from the input so it is valid one cycle
        // after done, without waiting for the snapshot write.
        out_data <= result_c[DATA_WIDTH-1:0];
`ifdef STREAM_LAST_EN
        out_last <= (N == 1);
`endif
      end else if (hs_last) begin
        frame_count <= frame_count + 8'd1;
`ifdef STREAM_LAST_EN
        out_last    <= 1'b0;
`endif
      end else if (handshake) begin
        idx      <= idx_inc;
        out_data <= snapshot[idx_inc];
        // Row/col run as their own counters so no divider is needed.
        if (out_col == LAST_COL) begin
          out_col <= '0;
          out_row <= out_row + ROW_W'(1);
        end else begin
          out_col <= out_col + COL_W'(1);
        end
`ifdef STREAM_LAST_EN
        out_last <= (idx_inc == LAST_IDX);
`endif
      end
    end
  end

endmodule

// File: tb/tb_result_stream_drain.sv
module tb_result_stream_drain;

  localparam int DW = 8;
  localparam int M  = 2;
  localparam int P  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        done;
  logic [31:0] result_c;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_row;
  logic [0:0]  out_col;
  logic        busy;
  logic        frame_done;
  logic        overrun;
  logic        clr_overrun;
  logic [7:0]  frame_count;
`ifdef STREAM_LAST_EN
  logic        out_last;
`endif

  int checks   = 0;
  int failures = 0;

  // Row-major order of 32'h04_03_02_01 on a 2x2 result.
  logic [7:0] exp_d [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
  logic [0:0] exp_r [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [0:0] exp_c [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  result_stream_drain #(
    .DATA_WIDTH(DW),
    .M(M),
    .P(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .done(done),
    .result_c(result_c),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row(out_row),
    .out_col(out_col),
    .busy(busy),
    .frame_done(frame_done),
    .overrun(overrun),
    .clr_overrun(clr_overrun),
    .frame_count(frame_count)
`ifdef STREAM_LAST_EN
    ,
    .out_last(out_last)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done(input logic [31:0] rc);
    result_c = rc;
    done     = 1'b1;
    tick();
    done     = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid, busy, frame_done, overrun} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {out_valid, busy, frame_done, overrun});
    end
    checks++;
    if ({frame_count, out_data, out_row, out_col} !== 18'h0) begin
      failures++;
      $display("FAIL reset_values got=%h exp=0", {frame_count, out_data, out_row, out_col});
    end
    #9 rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL idle_no_done got=%b exp=00", {out_valid, busy});
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    pulse_done(32'h04030201);
    for (int e = 0; e < 4; e++) begin
      checks++;
      if ({out_valid, busy, out_row, out_col, out_data} !== {1'b1, 1'b1, exp_r[e], exp_c[e], exp_d[e]}) begin
        failures++;
        $display("FAIL stream_elem%0d got=%h exp=%h", e, {out_valid, busy, out_row, out_col, out_data},
                 {1'b1, 1'b1, exp_r[e], exp_c[e], exp_d[e]});
      end
      checks++;
      if (frame_done !== 1'b0) begin
        failures++;
        $display("FAIL stream_early_done elem%0d got=%b exp=0", e, frame_done);
      end
`ifdef STREAM_LAST_EN
      checks++;
      if (out_last !== (e == 3)) begin
        failures++;
        $display("FAIL out_last elem%0d got=%b exp=%b", e, out_last, (e == 3));
      end
`endif
      tick();
    end
    checks++;
    if ({out_valid, busy, frame_done, frame_count} !== {3'b001, 8'd1}) begin
      failures++;
      $display("FAIL stream_end got=%h exp=%h", {out_valid, busy, frame_done, frame_count}, {3'b001, 8'd1});
    end
`ifdef STREAM_LAST_EN
    checks++;
    if (out_last !== 1'b0) begin
      failures++;
      $display("FAIL out_last_after got=%b exp=0", out_last);
    end
`endif
    tick();
    checks++;
    if ({frame_done, overrun} !== 2'b00) begin
      failures++;
      $display("FAIL stream_pulse_width got=%b exp=00", {frame_done, overrun});
    end
  endtask

  task automatic test_backpressure();
    bit pat [10] = '{0, 1, 0, 0, 1, 0, 1, 0, 0, 1};
    int acc = 0;
    out_ready = 1'b0;
    pulse_done(32'h04030201);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({out_valid, out_row, out_col, out_data} !== {1'b1, exp_r[acc], exp_c[acc], exp_d[acc]}) begin
        failures++;
        $display("FAIL bp_cycle%0d got=%h exp=%h", c, {out_valid, out_row, out_col, out_data},
                 {1'b1, exp_r[acc], exp_c[acc], exp_d[acc]});
      end
      out_ready = pat[c];
      tick();
      if (pat[c]) acc++;
    end
    out_ready = 1'b0;
    checks++;
    if ({out_valid, frame_done, frame_count} !== {2'b01, 8'd2}) begin
      failures++;
      $display("FAIL bp_end got=%h exp=%h", {out_valid, frame_done, frame_count}, {2'b01, 8'd2});
    end
  endtask

  task automatic test_overrun();
    out_ready = 1'b1;
    pulse_done(32'h04030201);
    checks++;
    if (out_data !== 8'h01) begin
      failures++;
      $display("FAIL ovr_elem0 got=%h exp=01", out_data);
    end
    tick();
    checks++;
    if (out_data !== 8'h02) begin
      failures++;
      $display("FAIL ovr_elem1 got=%h exp=02", out_data);
    end
    pulse_done(32'hFFFFFFFF);
    checks++;
    if ({overrun, out_data} !== {1'b1, 8'h03}) begin
      failures++;
      $display("FAIL ovr_elem2 got=%h exp=%h", {overrun, out_data}, {1'b1, 8'h03});
    end
    tick();
    checks++;
    if (out_data !== 8'h04) begin
      failures++;
      $display("FAIL ovr_elem3 got=%h exp=04", out_data);
    end
    tick();
    checks++;
    if ({out_valid, frame_done, overrun, frame_count} !== {3'b011, 8'd3}) begin
      failures++;
      $display("FAIL ovr_end got=%h exp=%h", {out_valid, frame_done, overrun, frame_count}, {3'b011, 8'd3});
    end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clear got=%b exp=0", overrun);
    end
  endtask

  // done on the final handshake is dropped; clear in the same cycle loses.
  task automatic test_overrun_edges();
    out_ready = 1'b1;
    pulse_done(32'h04030201);
    tick();
    tick();
    tick();
    result_c    = 32'hFFFFFFFF;
    done        = 1'b1;
    clr_overrun = 1'b1;
    tick();
    done        = 1'b0;
    clr_overrun = 1'b0;
    checks++;
    if ({overrun, out_valid, frame_done, frame_count} !== {3'b101, 8'd4}) begin
      failures++;
      $display("FAIL edge_last_hs got=%h exp=%h", {overrun, out_valid, frame_done, frame_count}, {3'b101, 8'd4});
    end
    tick();
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL edge_dropped_start got=%b exp=00", {out_valid, busy});
    end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL edge_clear got=%b exp=0", overrun);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    pulse_done(32'h04030201);
    tick();
    tick();
    checks++;
    if (out_data !== 8'h03) begin
      failures++;
      $display("FAIL mid_before got=%h exp=03", out_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, frame_done, frame_count} !== 11'h0) begin
      failures++;
      $display("FAIL mid_async got=%h exp=0", {out_valid, busy, frame_done, frame_count});
    end
    #2 rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({out_valid, frame_done} !== 2'b00) begin
        failures++;
        $display("FAIL mid_quiet%0d got=%b exp=00", c, {out_valid, frame_done});
      end
    end
    pulse_done(32'h08070605);
    for (int e = 0; e < 4; e++) begin
      checks++;
      if ({out_valid, out_row, out_col, out_data} !== {1'b1, exp_r[e], exp_c[e], exp_d[e] + 8'h04}) begin
        failures++;
        $display("FAIL mid_new_elem%0d got=%h exp=%h", e, {out_valid, out_row, out_col, out_data},
                 {1'b1, exp_r[e], exp_c[e], exp_d[e] + 8'h04});
      end
      tick();
    end
    checks++;
    if ({frame_done, frame_count} !== {1'b1, 8'd1}) begin
      failures++;
      $display("FAIL mid_new_end got=%h exp=%h", {frame_done, frame_count}, {1'b1, 8'd1});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    rst = 1'b1;
    #2 rst = 1'b0;
    out_ready = 1'b1;
    for (int f = 0; f < 256; f++) begin
      b = 8'(f);
      pulse_done({b + 8'd3, b + 8'd2, b + 8'd1, b});
      checks++;
      if ({frame_done, out_valid, out_data} !== {2'b01, b}) begin
        failures++;
        $display("FAIL b2b_first f=%0d got=%h exp=%h", f, {frame_done, out_valid, out_data}, {2'b01, b});
      end
      tick();
      tick();
      tick();
      checks++;
      if (out_data !== b + 8'd3) begin
        failures++;
        $display("FAIL b2b_last f=%0d got=%h exp=%h", f, out_data, b + 8'd3);
      end
      tick();
      checks++;
      if ({frame_done, frame_count} !== {1'b1, 8'(f + 1)}) begin
        failures++;
        $display("FAIL b2b_end f=%0d got=%h exp=%h", f, {frame_done, frame_count}, {1'b1, 8'(f + 1)});
      end
    end
    tick();
    checks++;
    if ({frame_done, out_valid, overrun, frame_count} !== 11'h0) begin
      failures++;
      $display("FAIL b2b_wrap got=%h exp=0", {frame_done, out_valid, overrun, frame_count});
    end
  endtask

  initial begin
    rst         = 1'b1;
    done        = 1'b0;
    out_ready   = 1'b0;
    clr_overrun = 1'b0;
    result_c    = '0;
    #3;
    test_reset();
    test_stream();
    test_backpressure();
    test_overrun();
    test_overrun_edges();
    test_reset_midstream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
